// File: rtl/data_lsu_pkg.sv
// Shared types and constants for the data_lsu load/store initiator.
package data_lsu_pkg;

    localparam int TAM_DEF     = 16;
    localparam int LMEM_DEF    = 8;
    localparam int MEM_LAT_MAX = 4;
    // The counter only ever holds MEM_LAT-1, so log2 of the maximum latency is enough
    localparam int CNT_W       = $clog2(MEM_LAT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD,
        WAIT,
        RESP,
        ERR
    } lsu_state_e;

endpackage

// File: rtl/data_lsu_lat_cnt.sv
// Loadable down-counter with a zero flag; times the DataMEM read latency.
module data_lsu_lat_cnt
    import data_lsu_pkg::*;
#(
    parameter int W = CNT_W
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload wins over decrement, and the count saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared by the active-low asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_lsu.sv
// data_lsu: per-core load/store initiator driving one DataMEM port.
// Optional feature macro: LSU_BOUNDS_CHECK_EN (rejects addresses with bits
// above LMEM set, answering with rsp_err instead of touching memory).
module data_lsu
    import data_lsu_pkg::*;
#(
    parameter int TAM     = TAM_DEF,
    parameter int LMEM    = LMEM_DEF,
    parameter int MEM_LAT = 1
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [TAM-1:0] req_addr,
    input  logic [TAM-1:0] req_data,
    output logic           rsp_valid,
    output logic [TAM-1:0] rsp_data,
    output logic           rsp_err,
    output logic [TAM-1:0] dataADDR,
    output logic [TAM-1:0] dataIN,
    output logic           dataWrite,
    output logic           dataLoad,
    input  logic [TAM-1:0] dataOUT
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    lsu_state_e     state_q;
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic           rsp_err_q;
    logic [TAM-1:0] rsp_data_q;
    logic [TAM-1:0] addr_q;
    logic [TAM-1:0] din_q;
    logic           write_q;
    logic           load_q;
    logic           cnt_zero;
    logic           oob;

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob = |req_addr[TAM-1:LMEM];
`else
    assign oob = 1'b0;
`endif

    data_lsu_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == LOAD),
        .load_val_i (LAT_LOAD),
        .dec_i      (state_q == WAIT),
        .zero_o     (cnt_zero)
    );

    // Command FSM; every port-facing output is a register updated here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            write_q     <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            write_q     <= 1'b0;
            load_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (oob) begin
                            state_q     <= ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            addr_q <= req_addr;
                            din_q  <= req_data;
                            if (req_write) begin
                                state_q     <= STORE;
                                write_q     <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= '0;
                            end else begin
                                state_q <= LOAD;
                                load_q  <= 1'b1;
                            end
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                STORE, ERR, RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                LOAD: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= dataOUT;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign dataADDR  = addr_q;
    assign dataIN    = din_q;
    assign dataWrite = write_q;
    assign dataLoad  = load_q;

endmodule

// File: tb/tb_data_lsu.sv
// Testbench for data_lsu: two instances (read latency 1 and 3), each with its
// own DataMEM model, checked against a word-level memory and timing model.
module tb_data_lsu;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][15:0] req_addr;
    logic [1:0][15:0] req_data;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_err;
    logic [1:0][15:0] rsp_data;
    logic [1:0][15:0] dataADDR;
    logic [1:0][15:0] dataIN;
    logic [1:0]       dataWrite;
    logic [1:0]       dataLoad;
    logic [1:0][15:0] dataOUT;

    logic [15:0] mem  [2][256];
    logic [15:0] pipe [2][4];

    logic [15:0] ref_mem [2][256];
    logic [15:0] exp_addr [2];
    logic [15:0] exp_din  [2];
    logic [15:0] exp_rsp  [2];

    int checks = 0;
    int fails  = 0;

    data_lsu #(.TAM(16), .LMEM(8), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .dataADDR(dataADDR[0]), .dataIN(dataIN[0]), .dataWrite(dataWrite[0]),
        .dataLoad(dataLoad[0]), .dataOUT(dataOUT[0])
    );

    data_lsu #(.TAM(16), .LMEM(8), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .dataADDR(dataADDR[1]), .dataIN(dataIN[1]), .dataWrite(dataWrite[1]),
        .dataLoad(dataLoad[1]), .dataOUT(dataOUT[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503) ^ 16'hA5C3;
    endfunction

    // DataMEM models: word array indexed by the low 8 address bits, read data
    // delivered through a delay line; junk fills cycles with no read pending
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int a = 0; a < 256; a++) mem[k][a] <= init_word(a);
                for (int j = 0; j < 4; j++) pipe[k][j] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (dataWrite[k]) mem[k][dataADDR[k][7:0]] <= dataIN[k];
                pipe[k][0] <= dataLoad[k] ? mem[k][dataADDR[k][7:0]] : 16'($urandom);
                for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
            end
        end
    end

    assign dataOUT[0] = pipe[0][0];
    assign dataOUT[1] = pipe[1][2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(a);
            exp_addr[k] = '0;
            exp_din[k]  = '0;
            exp_rsp[k]  = '0;
        end
    endtask

    // One command on instance k; optionally keeps req_valid high afterwards
    // with the next command so back-to-back acceptance can be observed
    task automatic do_op(input int k, input bit wr, input logic [15:0] addr,
                         input logic [15:0] data, input bit hold, input bit nwr,
                         input logic [15:0] naddr, input logic [15:0] ndata);
        int          lat;
        int          wdog;
        int          rsp_off;
        bit          oob;
        logic [15:0] new_rsp;
        logic [4:0]  exp_f;
        logic [4:0]  got_f;
        logic [15:0] exp_d;
        lat  = (k == 0) ? 1 : 3;
        wdog = 0;
        while (req_ready[k] !== 1'b1 && wdog < 20) begin
            tick;
            wdog++;
        end
        checks++;
        if (req_ready[k] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_timeout k=%0d got=%b exp=1", k, req_ready[k]);
            req_valid[k] = 1'b0;
            return;
        end
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_data[k]  = data;
        oob     = BOUNDS && (addr[15:8] != 8'h00);
        rsp_off = (wr || oob) ? 1 : 2 + lat;
        if (oob || wr) new_rsp = '0;
        else new_rsp = ref_mem[k][addr[7:0]];
        if (!oob) begin
            exp_addr[k] = addr;
            exp_din[k]  = data;
        end
        tick;
        if (hold) begin
            req_write[k] = nwr;
            req_addr[k]  = naddr;
            req_data[k]  = ndata;
        end else begin
            req_valid[k] = 1'b0;
        end
        for (int i = 1; i <= rsp_off + 1; i++) begin
            exp_f = {i == rsp_off + 1, i == rsp_off, (i == rsp_off) && oob,
                     (i == 1) && wr && !oob, (i == 1) && !wr && !oob};
            got_f = {req_ready[k], rsp_valid[k], rsp_err[k], dataWrite[k], dataLoad[k]};
            checks++;
            if (got_f !== exp_f) begin
                fails++;
                $display("[TB] FAIL flags{rdy,rv,err,wr,ld} k=%0d addr=%h cyc=T+%0d got=%b exp=%b",
                         k, addr, i, got_f, exp_f);
            end
            exp_d = (i >= rsp_off) ? new_rsp : exp_rsp[k];
            checks++;
            if (rsp_data[k] !== exp_d) begin
                fails++;
                $display("[TB] FAIL rsp_data k=%0d addr=%h cyc=T+%0d got=%h exp=%h",
                         k, addr, i, rsp_data[k], exp_d);
            end
            checks++;
            if (dataADDR[k] !== exp_addr[k] || dataIN[k] !== exp_din[k]) begin
                fails++;
                $display("[TB] FAIL addr_din k=%0d cyc=T+%0d got=%h/%h exp=%h/%h",
                         k, i, dataADDR[k], dataIN[k], exp_addr[k], exp_din[k]);
            end
            if (i <= rsp_off) tick;
        end
        exp_rsp[k] = new_rsp;
        if (wr && !oob) ref_mem[k][addr[7:0]] = data;
    endtask

    task automatic test_reset;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_data  = '0;
        rst = 1'b0;
        reset_model();
        #3;
        tick;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({req_ready[k], rsp_valid[k], rsp_err[k], dataWrite[k], dataLoad[k]} !== 5'b0 ||
                rsp_data[k] !== '0 || dataADDR[k] !== '0 || dataIN[k] !== '0) begin
                fails++;
                $display("[TB] FAIL reset_state k=%0d got=%b %h %h %h exp=0", k,
                         {req_ready[k], rsp_valid[k], rsp_err[k], dataWrite[k], dataLoad[k]},
                         rsp_data[k], dataADDR[k], dataIN[k]);
            end
        end
        tick;
        rst = 1'b1;
        checks++;
        if (req_ready !== 2'b00) begin
            fails++;
            $display("[TB] FAIL ready_before_edge got=%b exp=00", req_ready);
        end
        tick;
        checks++;
        if (req_ready !== 2'b11) begin
            fails++;
            $display("[TB] FAIL ready_after_edge got=%b exp=11", req_ready);
        end
    endtask

    task automatic test_store;
        do_op(0, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_load_after_store;
        do_op(0, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_lat3_held;
        do_op(1, 1'b1, 16'h00FF, 16'h1234, 1'b0, 1'b0, '0, '0);
        do_op(1, 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h5555);
        do_op(1, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b0, '0, '0);
        do_op(1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back;
        do_op(0, 1'b1, 16'h0030, 16'hCAFE, 1'b1, 1'b0, 16'h0030, 16'h0000);
        do_op(0, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_bounds;
        do_op(0, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, '0, '0);
        do_op(1, 1'b1, 16'h0105, 16'hABCD, 1'b0, 1'b0, '0, '0);
        do_op(1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, '0, '0);
        do_op(1, 1'b0, 16'hF3A7, 16'h0000, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_load;
        int wdog;
        wdog = 0;
        while (req_ready[1] !== 1'b1 && wdog < 20) begin
            tick;
            wdog++;
        end
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 16'h0040;
        tick;
        req_valid[1] = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        reset_model();
        #1;
        checks++;
        if ({req_ready[1], rsp_valid[1], rsp_err[1], dataWrite[1], dataLoad[1]} !== 5'b0 ||
            rsp_data[1] !== '0 || dataADDR[1] !== '0 || dataIN[1] !== '0) begin
            fails++;
            $display("[TB] FAIL midload_reset got=%b %h %h %h exp=0",
                     {req_ready[1], rsp_valid[1], rsp_err[1], dataWrite[1], dataLoad[1]},
                     rsp_data[1], dataADDR[1], dataIN[1]);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (rsp_valid !== 2'b00 || dataLoad !== 2'b00) begin
                fails++;
                $display("[TB] FAIL midload_no_rsp got=%b/%b exp=00/00", rsp_valid, dataLoad);
            end
        end
        rst = 1'b1;
        checks++;
        if (req_ready[1] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midload_ready_early got=%b exp=0", req_ready[1]);
        end
        tick;
        checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midload_ready_release got=%b/%b exp=1/0", req_ready[1], rsp_valid[1]);
        end
    endtask

    task automatic test_random;
        int          k;
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        for (int n = 0; n < 80; n++) begin
            k  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) a = 16'($urandom);
            else a = {8'h00, 8'($urandom_range(0, 31))};
            d = 16'($urandom);
            do_op(k, wr, a, d, 1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_after_store();
        test_lat3_held();
        test_back_to_back();
        test_bounds();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
